// File: rtl/phase_detector_tdc.sv
// Counter-based phase/frequency detector and TDC for the ADPLL: signed, saturated, held error word.
// Optional lock detector built when PHASE_DETECTOR_LOCK_DETECT_EN is defined; otherwise lock_o is tied to 0.
module phase_detector_tdc #(
   parameter int ERROR_WIDTH = 8,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_COUNT  = 16
) (
   input  logic                          gen_clk_i,
   input  logic                          reset_i,
   input  logic                          ref_clk_i,
   input  logic                          fb_clk_i,
   output logic signed [ERROR_WIDTH-1:0] error_o,
   output logic                          error_valid_o,
   output logic                          lock_o
);

   localparam int               CNT_W = ERROR_WIDTH - 1;
   localparam logic [CNT_W-1:0] MAXV  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   if (SYNC_STAGES < 2 || ERROR_WIDTH < 2 || LOCK_COUNT < 1 || LOCK_TOL < 0) begin : g_param_check
      $error("phase_detector_tdc: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

   logic [SYNC_STAGES-1:0] ref_sync;
   logic [SYNC_STAGES-1:0] fb_sync;
   logic                   ref_hist;
   logic                   fb_hist;
   logic                   ref_rise;
   logic                   fb_rise;

   state_t                        state;
   logic [CNT_W-1:0]              cnt;
   logic [CNT_W-1:0]              cnt_inc;
   logic signed [ERROR_WIDTH-1:0] cnt_pos;
   logic signed [ERROR_WIDTH-1:0] cnt_neg;
   logic signed [ERROR_WIDTH-1:0] max_pos;
   logic signed [ERROR_WIDTH-1:0] max_neg;

   // Both inputs are asynchronous; the history flop sits behind the last sync stage.
   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         ref_sync <= '0;
         fb_sync  <= '0;
         ref_hist <= 1'b0;
         fb_hist  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
         ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_clk_i};
         fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_clk_i};
         ref_hist <= ref_sync[SYNC_STAGES-1];
         fb_hist  <= fb_sync[SYNC_STAGES-1];
      end
   end

   assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_hist;
   assign fb_rise  = fb_sync[SYNC_STAGES-1] & ~fb_hist;

   assign cnt_inc = (cnt == MAXV) ? cnt : cnt + ONE;
   assign cnt_pos = $signed({1'b0, cnt});
   assign cnt_neg = -cnt_pos;
   assign max_pos = $signed({1'b0, MAXV});
   assign max_neg = -max_pos;

   // Range stays symmetric (+/-MAXV); the most negative code is never produced.
   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state         <= IDLE;
         cnt           <= '0;
         error_o       <= '0;
         error_valid_o <= 1'b0;
      end else begin
         error_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ref_rise && fb_rise) begin
                  error_o       <= '0;
                  error_valid_o <= 1'b1;
               end else if (ref_rise) begin
                  cnt   <= ONE;
                  state <= REF_LEAD;
               end else if (fb_rise) begin
                  cnt   <= ONE;
                  state <= FB_LEAD;
               end
            end
            REF_LEAD: begin
               if (fb_rise) begin
                  error_o       <= cnt_pos;
                  error_valid_o <= 1'b1;
                  if (ref_rise) cnt   <= ONE;
                  else          state <= IDLE;
               end else if (ref_rise) begin
                  // Feedback edge missed: report a full-scale frequency error and restart.
                  error_o       <= max_pos;
                  error_valid_o <= 1'b1;
                  cnt           <= ONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            FB_LEAD: begin
               if (ref_rise) begin
                  error_o       <= cnt_neg;
                  error_valid_o <= 1'b1;
                  if (fb_rise) cnt   <= ONE;
                  else         state <= IDLE;
               end else if (fb_rise) begin
                  error_o       <= max_neg;
                  error_valid_o <= 1'b1;
                  cnt           <= ONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PHASE_DETECTOR_LOCK_DETECT_EN
   localparam int                     LCK_W   = $clog2(LOCK_COUNT + 1);
   localparam logic [LCK_W-1:0]       LCNT_V  = LCK_W'(LOCK_COUNT);
   localparam logic [LCK_W-1:0]       LCNT_M1 = LCK_W'(LOCK_COUNT - 1);
   localparam logic [ERROR_WIDTH-1:0] TOL_V   = ERROR_WIDTH'(LOCK_TOL);

   logic [LCK_W-1:0]       lock_cnt;
   logic [ERROR_WIDTH-1:0] err_abs;
   logic                   in_tol;

   assign err_abs = error_o[ERROR_WIDTH-1] ? -error_o : error_o;
   assign in_tol  = (err_abs <= TOL_V);

   // Works off the registered publish, so lock_o moves in the cycle after it.
   always_ff @(posedge gen_clk_i or posedge reset_i) begin
      if (reset_i) begin
         lock_cnt <= '0;
         lock_o   <= 1'b0;
      end else if (error_valid_o) begin
         if (in_tol) begin
            if (lock_cnt != LCNT_V) lock_cnt <= lock_cnt + 1'b1;
            lock_o <= (lock_cnt >= LCNT_M1);
         end else begin
            lock_cnt <= '0;
            lock_o   <= 1'b0;
         end
      end
   end
`else
   assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_phase_detector_tdc.sv
// Self-checking bench for phase_detector_tdc: directed scenarios plus random edges against a timestamp model.
// Lock expectations follow PHASE_DETECTOR_LOCK_DETECT_EN as used for the DUT build.
module tb_phase_detector_tdc;

   localparam int ERROR_WIDTH = 8;
   localparam int SYNC_STAGES = 2;
   localparam int LOCK_TOL    = 2;
   localparam int LOCK_COUNT  = 4;
   localparam int MAXV        = (1 << (ERROR_WIDTH - 1)) - 1;
`ifdef PHASE_DETECTOR_LOCK_DETECT_EN
   localparam int LOCK_EN = 1;
`else
   localparam int LOCK_EN = 0;
`endif

   logic                          gen_clk_i = 1'b0;
   logic                          reset_i;
   logic                          ref_clk_i;
   logic                          fb_clk_i;
   logic signed [ERROR_WIDTH-1:0] error_o;
   logic                          error_valid_o;
   logic                          lock_o;

   phase_detector_tdc #(
      .ERROR_WIDTH(ERROR_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .LOCK_TOL   (LOCK_TOL),
      .LOCK_COUNT (LOCK_COUNT)
   ) dut (
      .gen_clk_i    (gen_clk_i),
      .reset_i      (reset_i),
      .ref_clk_i    (ref_clk_i),
      .fb_clk_i     (fb_clk_i),
      .error_o      (error_o),
      .error_valid_o(error_valid_o),
      .lock_o       (lock_o)
   );

   always #5 gen_clk_i = ~gen_clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   // Reference model: edges as timestamps, measurement = closing time minus opening time.
   bit ref_q[$];
   bit fb_q[$];
   bit ref_prev, fb_prev;
   int open_sign;
   int t_open;
   int cyc;
   int exp_err;
   int exp_valid;
   int exp_lock;
   int lk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ref_q.delete();
      fb_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
         ref_q.push_back(1'b0);
         fb_q.push_back(1'b0);
      end
      ref_prev  = 1'b0;
      fb_prev   = 1'b0;
      open_sign = 0;
      t_open    = 0;
      exp_err   = 0;
      exp_valid = 0;
      exp_lock  = 0;
      lk        = 0;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_cycle(input bit rr, input bit fr);
      bit opener, closer;
      int dur;
      if (exp_valid != 0) begin
         if (iabs(exp_err) <= LOCK_TOL) lk = (lk + 1 > LOCK_COUNT) ? LOCK_COUNT : lk + 1;
         else                           lk = 0;
      end
      exp_lock  = (LOCK_EN != 0 && lk >= LOCK_COUNT) ? 1 : 0;
      exp_valid = 0;
      if (open_sign == 0) begin
         if (rr && fr) begin
            exp_err = 0; exp_valid = 1;
         end else if (rr) begin
            open_sign = 1; t_open = cyc;
         end else if (fr) begin
            open_sign = -1; t_open = cyc;
         end
      end else begin
         opener = (open_sign > 0) ? rr : fr;
         closer = (open_sign > 0) ? fr : rr;
         if (closer) begin
            dur = cyc - t_open;
            if (dur > MAXV) dur = MAXV;
            exp_err = open_sign * dur; exp_valid = 1;
            if (opener) t_open = cyc;
            else        open_sign = 0;
         end else if (opener) begin
            exp_err = open_sign * MAXV; exp_valid = 1;
            t_open = cyc;
         end
      end
      cyc++;
   endtask

   // One gen_clk_i cycle: compare outputs, drive new input levels, advance the model.
   task automatic step(input bit r, input bit f);
      bit rr, fr;
      @(negedge gen_clk_i);
      check("error_o", error_o, exp_err);
      check("error_valid_o", error_valid_o, exp_valid);
      check("lock_o", lock_o, exp_lock);
      if (error_valid_o) pulses++;
      ref_clk_i = r;
      fb_clk_i  = f;
      ref_q.push_back(r & ~ref_prev);
      fb_q.push_back(f & ~fb_prev);
      ref_prev = r;
      fb_prev  = f;
      rr = ref_q.pop_front();
      fr = fb_q.pop_front();
      model_cycle(rr, fr);
   endtask

   // Leading input rises, the other rises n cycles later (n = 0: same cycle).
   task automatic measure(input bit ref_first, input int n);
      repeat (4) step(1'b0, 1'b0);
      repeat (n) step(ref_first, !ref_first);
      repeat (3) step(1'b1, 1'b1);
      repeat (6) step(1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] raw;
      bit cur_r, cur_f;
      reset_i   = 1'b1;
      ref_clk_i = 1'b0;
      fb_clk_i  = 1'b0;
      cyc       = 0;
      model_reset();
      repeat (3) @(negedge gen_clk_i);
      check("rst_error", error_o, 0);
      check("rst_valid", error_valid_o, 0);
      check("rst_lock", lock_o, 0);
      reset_i = 1'b0;

      // Lock qualification: +1, 0, -2, +1, then an out-of-tolerance +3.
      measure(1'b1, 1);
      measure(1'b1, 0);
      measure(1'b0, 2);
      measure(1'b1, 1);
      check("lock_after_4", lock_o, LOCK_EN);
      measure(1'b1, 3);
      check("err_plus3", error_o, 3);
      check("lock_after_big", lock_o, 0);

      pulses = 0;
      measure(1'b1, 5);
      check("ref_lead5", error_o, 5);
      check("ref_lead5_pulses", pulses, 1);
      repeat (5) step(1'b0, 1'b0);
      check("ref_lead5_hold", error_o, 5);

      measure(1'b0, 3);
      check("fb_lead3", error_o, -3);
      raw = error_o;
      check("fb_lead3_raw", raw, 8'hFD);

      pulses = 0;
      measure(1'b1, 0);
      check("simult", error_o, 0);
      check("simult_pulses", pulses, 1);

      // Close and reopen in the same cycle: +4, then the reopened measurement closes at +3.
      pulses = 0;
      repeat (4) step(1'b0, 1'b0);
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
      repeat (6) step(1'b0, 1'b0);
      check("reopen_err", error_o, 3);
      check("reopen_pulses", pulses, 2);

      // Feedback stopped, reference rising every 300 cycles, then a late feedback edge.
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         repeat (150) step(1'b1, 1'b0);
         repeat (150) step(1'b0, 1'b0);
      end
      repeat (50) step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0);
      check("sat_err", error_o, MAXV);
      check("sat_pulses", pulses, 3);

      cur_r = 1'b0;
      cur_f = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) cur_r = !cur_r;
         if ($urandom_range(0, 7) == 0) cur_f = !cur_f;
         step(cur_r, cur_f);
      end

      // Reset in the middle of a REF_LEAD count.
      measure(1'b1, 5);
      repeat (4) step(1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0);
      @(negedge gen_clk_i);
      reset_i = 1'b1;
      #1;
      check("midrst_error", error_o, 0);
      check("midrst_valid", error_valid_o, 0);
      check("midrst_lock", lock_o, 0);
      ref_clk_i = 1'b0;
      fb_clk_i  = 1'b0;
      repeat (3) @(negedge gen_clk_i);
      reset_i = 1'b0;
      model_reset();
      pulses = 0;
      repeat (10) step(1'b0, 1'b0);
      check("midrst_no_pulse", pulses, 0);
      measure(1'b1, 2);
      check("post_rst_meas", error_o, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_detector_tdc.md
# phase_detector_tdc

Counter-based phase/frequency detector and time-to-digital converter for the ADPLL. It sits directly upstream of the loop filter. It samples the reference clock and the divided DCO feedback clock in the fast `gen_clk_i` domain and measures the gap between their rising edges in `gen_clk_i` cycles. It presents the result as a signed, saturated, held error word that the loop filter consumes every cycle.

## Interface
- `ERROR_WIDTH`, 8: width of the signed error word; must match the loop filter's error input width.
- `SYNC_STAGES`, 2: synchroniser depth for `ref_clk_i` and `fb_clk_i`; minimum 2.
- `LOCK_TOL`, 2: maximum |error| counted as in-lock (lock detector only).
- `LOCK_COUNT`, 16: consecutive in-tolerance measurements required to assert lock.

Ports:
- `gen_clk_i`, in, 1: sampling/system clock.
- `reset_i`, in, 1: reset, asynchronous, active-high.
- `ref_clk_i`, in, 1: reference clock, asynchronous to `gen_clk_i`.
- `fb_clk_i`, in, 1: divided DCO feedback clock, asynchronous to `gen_clk_i`.
- `error_o`, out, `ERROR_WIDTH`, signed: last measured phase error. Positive means ref leads fb, i.e. the DCO is slow.
- `error_valid_o`, out, 1: one-cycle pulse when `error_o` updates.
- `lock_o`, out, 1: lock indicator.

## Operation
- Each input passes through a `SYNC_STAGES`-deep flop chain followed by one history flop. A rising edge (`ref_rise`, `fb_rise`) is flagged when the history flop is 0 and the last sync stage is 1.
- `MAXV` = 2^(`ERROR_WIDTH`-1)-1. The counter `cnt` saturates at `MAXV`.
- The state machine has three states: IDLE, REF_LEAD, FB_LEAD.
- In IDLE:
  - `ref_rise` and `fb_rise` together: publish 0; stay in IDLE.
  - `ref_rise` only: `cnt`=1; go to REF_LEAD.
  - `fb_rise` only: `cnt`=1; go to FB_LEAD.
- In REF_LEAD:
  - `fb_rise`: publish +`cnt`. If `ref_rise` is also high, set `cnt`=1 and stay in REF_LEAD; otherwise go to IDLE.
  - `ref_rise` without `fb_rise` (missed feedback edge): publish +`MAXV`; `cnt`=1; stay in REF_LEAD.
  - No edge: `cnt`++, saturating at `MAXV`.
- FB_LEAD mirrors REF_LEAD: the closing edge is `ref_rise`, the published value is -`cnt`, and a missed edge publishes -`MAXV`.
- The output range is symmetric, ±`MAXV`. The value -2^(`ERROR_WIDTH`-1) is never produced.
- "Publish" means: `error_o` is registered with the value, and `error_valid_o`=1 for one cycle. `error_o` holds between publishes.
- A frequency error shows up as repeated saturated values of the same sign, so the detector acts as a PFD.

## Timing
- Reset values: all sync flops 0, state IDLE, `cnt`=0, `error_o`=0, `error_valid_o`=0, `lock_o`=0.
- Reset asserted mid-measurement aborts it with no publish. After release, a measurement starts only on a fresh synchronised edge.
- Edge-detect latency: an input edge is flagged `SYNC_STAGES` to `SYNC_STAGES`+1 cycles after it occurs.
- Opening edge flagged in cycle t, closing edge flagged in cycle t+N: `error_o`=±N, visible from cycle t+N+1, with `error_valid_o` high in t+N+1 only.
- Resolution is ±1 `gen_clk_i` cycle of synchroniser uncertainty per edge.
- The loop filter registers `error_o` every cycle. It does not use `error_valid_o`.

## Configuration
- Macro: `PHASE_DETECTOR_LOCK_DETECT_EN`.
- Defined: a lock counter is built.
  - Each publish with |value| ≤ `LOCK_TOL` increments the counter, saturating at `LOCK_COUNT`.
  - Any other publish clears the counter and deasserts `lock_o` in the cycle after that publish.
  - `lock_o`=1 once the counter reaches `LOCK_COUNT`. It is registered and asserts in the cycle after the qualifying publish.
- Not defined: no lock counter is built; `lock_o` is tied to 0.

## Test plan
- Reset check: assert `reset_i` during an active REF_LEAD count → `error_o`=0, `lock_o`=0, state IDLE. After release, no spurious `error_valid_o`.
- Ref leads fb by 5 `gen_clk_i` cycles → `error_o`=+5, exactly one `error_valid_o` pulse; the value is held afterwards.
- Fb leads ref by 3 cycles → `error_o`=-3 (8'hFD).
- Simultaneous edges in the same `gen_clk_i` cycle → `error_o`=0 with a valid pulse. Separately, in REF_LEAD with closing `fb_rise` and new `ref_rise` in the same cycle → publish +`cnt` and remain in REF_LEAD with `cnt`=1.
- `ERROR_WIDTH`=8, fb stopped and ref toggling every 300 cycles → every publish is +127; `cnt` never wraps.
- With `PHASE_DETECTOR_LOCK_DETECT_EN`, `LOCK_COUNT`=4:
  - Errors +1, 0, -2, +1 → `lock_o` rises in the cycle after the 4th publish.
  - A subsequent +3 → `lock_o` falls in the cycle after that publish.
